butterfly_pipe: RTL
===================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter DW, default 16: signed width of data inputs a/b and outputs y0/y1.
REQ-002 Parameter TW, default 16: signed twiddle width, format Q1.(TW-1) (0x7FFF ~ +1.0, 0x8000 = -1.0 for TW=16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a_re, a_im, b_re, b_im  input  DW each  signed operands.
REQ-008 tw_re, tw_im  input  TW each  signed twiddle, sampled with the beat.
REQ-009 scale_en  input  1  per-beat divide-by-2 mode, sampled with the beat.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 y0_re, y0_im, y1_re, y1_im  output  DW each  signed results.
REQ-013 ovf  output  1  per-beat flag: this result saturated.
REQ-014 ovf_sticky  output  1  set by any accepted saturated output; cleared by ovf_clr or rst.
REQ-015 ovf_clr  input  1  clears ovf_sticky; ovf_clr wins over a simultaneous set.

Function
REQ-016 Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
REQ-017 Three register stages S1..S3; latency exactly 3 cycles from input transfer to out_valid with no stall.
REQ-018 Pipeline advance enable adv = out_ready | ~out_valid; in_ready = adv (combinational); all stages hold when adv=0.
REQ-019 Bubbles propagate: each stage carries a valid bit; when adv=1 an empty stage accepts the previous stage's content.
REQ-020 Full throughput: one beat per cycle while in_valid=1 and out_ready=1.
REQ-021 S1: register four full-precision products br*twr, bi*twi, br*twi, bi*twr (DW+TW bits), a, scale_en.
REQ-022 S2: m_re = br*twr - bi*twi, m_im = br*twi + bi*twr (DW+TW+1 bits); add 2^(TW-2), arithmetic shift right TW-1 (round half up); keep DW+2 bits.
REQ-023 S3: y0 = a + m, y1 = a - m at DW+3 bits; if scale_en, add 1 then arithmetic shift right 1.
REQ-024 S3: saturate each of the four results to [-2^(DW-1), 2^(DW-1)-1]; ovf = OR of the four saturation events.
REQ-025 No intermediate truncation before the final saturation; twiddle -1.0 handled exactly.
REQ-026 Output registers and ovf hold stable while out_valid=1 and out_ready=0.
REQ-027 ovf_sticky sets only on an output transfer with ovf=1.

Reset
REQ-028 On rst: all stage valid bits, out_valid, ovf, ovf_sticky = 0; y outputs = 0; in_ready = 1 in the following cycle.
REQ-029 rst mid-operation discards all in-flight beats; none emerges after reset deasserts.

Structure
REQ-030 Shared package bfly_pkg: default DW/TW constants, rounding/saturation functions, and a complex-sample struct typedef parametrised by width.
REQ-031 One sub-module cmul_pipe (S1-S2 complex multiply with rounding), reused by future radix-4 and FFT stage blocks.

Verification (DW=16, TW=16)
REQ-032 a=(2000,0), b=(1000,0), tw=(0x7FFF,0), scale_en=0 -> y0=(3000,0), y1=(1000,0), ovf=0, 3 cycles later.
REQ-033 a=(0,0), b=(1000,-500), tw=(0x8000,0) -> y0=(-1000,500), y1=(1000,-500), exact.
REQ-034 a=(32767,0), b=(32767,0), tw=(0x7FFF,0): scale_en=0 -> y0_re=32767, y1_re=1, ovf=1, ovf_sticky=1; scale_en=1 -> y0_re=32767, y1_re=1, ovf=0.
REQ-035 Back-pressure: 6 consecutive beats, out_ready held 0 for 5 cycles after first out_valid -> in_ready drops, outputs stable, all 6 results emerge in order, none lost or duplicated.
REQ-036 Reset mid-stream with 3 beats in flight -> out_valid=0 cycle after rst, ovf_sticky=0, no stale beat afterwards; ovf_clr asserted together with a saturating output -> ovf_sticky=0.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared butterfly definitions: default widths, sample type and
// the rounding / saturation helpers used by the FFT datapaths.
package bfly_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;
    localparam int XW     = 64;

    // Wide signed working type; every intermediate fits without loss.
    typedef logic signed [XW-1:0] wide_t;

    // Complex sample at the default data width.
    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    // Round half up, then arithmetic shift right by sh (sh >= 1).
    function automatic wide_t rnd_shr(input wide_t x, input int sh);
        return (x + (wide_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

    // Clamp x into the signed range of a w-bit word.
    function automatic wide_t sat_val(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // True when x lies outside the signed range of a w-bit word.
    function automatic logic sat_hit(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/butterfly_pipe_cmul.sv
// Two-stage complex multiply b*tw with round-half-up to DW+2 bits;
// an opaque sideband word travels alongside for the caller.
module cmul_pipe
    import bfly_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int TW  = TW_DEF,
    parameter int SBW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic signed [DW-1:0] i_br,
    input  logic signed [DW-1:0] i_bi,
    input  logic signed [TW-1:0] i_twr,
    input  logic signed [TW-1:0] i_twi,
    input  logic [SBW-1:0]       i_sb,
    output logic                 o_valid,
    output logic signed [DW+1:0] o_mre,
    output logic signed [DW+1:0] o_mim,
    output logic [SBW-1:0]       o_sb
);

    localparam int PW = DW + TW;
    localparam int MW = DW + TW + 1;
    localparam int OW = DW + 2;

    logic                 r_v1;
    logic                 r_v2;
    logic signed [PW-1:0] r_p_rr;
    logic signed [PW-1:0] r_p_ii;
    logic signed [PW-1:0] r_p_ri;
    logic signed [PW-1:0] r_p_ir;
    logic [SBW-1:0]       r_sb1;
    logic [SBW-1:0]       r_sb2;
    logic signed [OW-1:0] r_mre;
    logic signed [OW-1:0] r_mim;
    logic signed [MW-1:0] w_mre;
    logic signed [MW-1:0] w_mim;

    assign w_mre = MW'(r_p_rr) - MW'(r_p_ii);
    assign w_mim = MW'(r_p_ri) + MW'(r_p_ir);

    // Valid bits advance with the shared pipeline enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (i_en) begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
        end
    end

    // S1 full-precision products, S2 sum/difference and rounding.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_p_rr <= PW'(i_br) * PW'(i_twr);
            r_p_ii <= PW'(i_bi) * PW'(i_twi);
            r_p_ri <= PW'(i_br) * PW'(i_twi);
            r_p_ir <= PW'(i_bi) * PW'(i_twr);
            r_sb1  <= i_sb;
            r_mre  <= OW'(rnd_shr(wide_t'(w_mre), TW - 1));
            r_mim  <= OW'(rnd_shr(wide_t'(w_mim), TW - 1));
            r_sb2  <= r_sb1;
        end
    end

    assign o_valid = r_v2;
    assign o_mre   = r_mre;
    assign o_mim   = r_mim;
    assign o_sb    = r_sb2;

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly: y0 = a + b*tw, y1 = a - b*tw, optional /2,
// saturated to DW bits, three stages with valid/ready back-pressure.
module butterfly_pipe
    import bfly_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    input  logic                 scale_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] y0_re,
    output logic signed [DW-1:0] y0_im,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im,
    output logic                 ovf,
    output logic                 ovf_sticky,
    input  logic                 ovf_clr
);

    localparam int SBW = 2 * DW + 1;

    logic                 w_adv;
    logic                 w_v2;
    logic signed [DW+1:0] w_mre;
    logic signed [DW+1:0] w_mim;
    logic [SBW-1:0]       w_sb;
    logic                 w_sc;
    logic signed [DW-1:0] w_are;
    logic signed [DW-1:0] w_aim;
    wide_t                w_sum [4];
    wide_t                w_scl [4];
    logic signed [DW-1:0] w_sat [4];
    logic [3:0]           w_hit;

    logic                 r_v3;
    logic signed [DW-1:0] r_y [4];
    logic                 r_ovf;
    logic                 r_sticky;

    assign w_adv    = out_ready | ~r_v3;
    assign in_ready = w_adv;

    cmul_pipe #(
        .DW  (DW),
        .TW  (TW),
        .SBW (SBW)
    ) u_cmul (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_valid (in_valid),
        .i_br    (b_re),
        .i_bi    (b_im),
        .i_twr   (tw_re),
        .i_twi   (tw_im),
        .i_sb    ({scale_en, a_re, a_im}),
        .o_valid (w_v2),
        .o_mre   (w_mre),
        .o_mim   (w_mim),
        .o_sb    (w_sb)
    );

    assign w_sc  = w_sb[SBW-1];
    assign w_are = w_sb[2*DW-1:DW];
    assign w_aim = w_sb[DW-1:0];

    // S3 add/subtract, optional rounded halving, saturation to DW.
    always_comb begin
        w_sum[0] = wide_t'(w_are) + wide_t'(w_mre);
        w_sum[1] = wide_t'(w_aim) + wide_t'(w_mim);
        w_sum[2] = wide_t'(w_are) - wide_t'(w_mre);
        w_sum[3] = wide_t'(w_aim) - wide_t'(w_mim);
        w_hit    = '0;
        for (int i = 0; i < 4; i++) begin
            w_scl[i] = w_sc ? rnd_shr(w_sum[i], 1) : w_sum[i];
            w_sat[i] = DW'(sat_val(w_scl[i], DW));
            w_hit[i] = sat_hit(w_scl[i], DW);
        end
    end

    // Output stage register; holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3  <= 1'b0;
            r_ovf <= 1'b0;
            for (int i = 0; i < 4; i++) r_y[i] <= '0;
        end else if (w_adv) begin
            r_v3  <= w_v2;
            r_ovf <= w_v2 & (|w_hit);
            for (int i = 0; i < 4; i++) r_y[i] <= w_sat[i];
        end
    end

    // Sticky overflow: set on a saturated output transfer, clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (ovf_clr) begin
            r_sticky <= 1'b0;
        end else if (r_v3 && out_ready && r_ovf) begin
            r_sticky <= 1'b1;
        end
    end

    assign out_valid  = r_v3;
    assign y0_re      = r_y[0];
    assign y0_im      = r_y[1];
    assign y1_re      = r_y[2];
    assign y1_im      = r_y[3];
    assign ovf        = r_ovf;
    assign ovf_sticky = r_sticky;

endmodule
